// File: rtl/scarv_mem_arbiter.sv
// Merges the SCARV instruction and data memory ports onto one downstream port.
// Requests are granted round-robin and responses are steered back in request order via an ID FIFO.
module scarv_mem_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        imem_req,
  input  logic        imem_wen,
  input  logic [3:0]  imem_strb,
  input  logic [31:0] imem_wdata,
  input  logic [31:0] imem_addr,
  output logic        imem_gnt,
  output logic        imem_recv,
  output logic        imem_error,
  output logic [31:0] imem_rdata,
  input  logic        imem_ack,

  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_ack,

  output logic        m_req,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_wdata,
  output logic [31:0] m_addr,
  input  logic        m_gnt,
  input  logic        m_recv,
  input  logic        m_error,
  input  logic [31:0] m_rdata,
  output logic        m_ack
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] id_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             last_grant_q;
  logic             hold_valid_q;
  logic             hold_sel_q;
  logic             proto_err_q;

  logic fifo_full;
  logic fifo_empty;
  logic head_id;
  logic rr_sel;
  logic held_live;
  logic sel;
  logic push;
  logic pop;

  // A request left waiting for m_gnt keeps its selection so the downstream
  // request stays stable, unless that requester withdraws.
  always_comb begin
    fifo_full  = (count_q == CW'(DEPTH));
    fifo_empty = (count_q == '0);
    head_id    = id_q[rd_ptr_q];
    rr_sel     = (imem_req && dmem_req) ? ~last_grant_q : dmem_req;
    held_live  = hold_valid_q && (hold_sel_q ? dmem_req : imem_req);
    sel        = held_live ? hold_sel_q : rr_sel;

    m_req   = rst_ni && (imem_req || dmem_req) && !fifo_full;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    m_addr  = '0;
    if (m_req) begin
      m_wen   = sel ? dmem_wen   : imem_wen;
      m_strb  = sel ? dmem_strb  : imem_strb;
      m_wdata = sel ? dmem_wdata : imem_wdata;
      m_addr  = sel ? dmem_addr  : imem_addr;
    end

    push     = m_req && m_gnt;
    imem_gnt = push && !sel;
    dmem_gnt = push && sel;

    imem_recv  = !fifo_empty && !head_id && m_recv;
    dmem_recv  = !fifo_empty &&  head_id && m_recv;
    imem_error = !fifo_empty && !head_id && m_error;
    dmem_error = !fifo_empty &&  head_id && m_error;
    imem_rdata = (!fifo_empty && !head_id) ? m_rdata : '0;
    dmem_rdata = (!fifo_empty &&  head_id) ? m_rdata : '0;

    // A response with nothing outstanding is acknowledged so the adapter never stalls.
    if (!rst_ni)         m_ack = 1'b0;
    else if (fifo_empty) m_ack = m_recv;
    else                 m_ack = head_id ? dmem_ack : imem_ack;

    pop = m_recv && m_ack && !fifo_empty;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_sel_q   <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= wr_ptr_q + AW'(1);
        last_grant_q   <= sel;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      hold_valid_q <= m_req && !m_gnt;
      hold_sel_q   <= sel;
      if (m_recv && fifo_empty) proto_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scarv_mem_arbiter.sv
// Self-checking bench for scarv_mem_arbiter: directed table, corner sequences
// and a randomized run against a queue-based reference model.
module tb_scarv_mem_arbiter;

  localparam int DEPTH = 2;
  localparam logic [31:0] IA = 32'h0000_1000;
  localparam logic [31:0] DA = 32'h0000_2000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req = 0, imem_wen = 0, imem_ack = 0;
  logic [3:0]  imem_strb = 4'h3;
  logic [31:0] imem_wdata = 32'h1111_0000, imem_addr = IA;
  logic        imem_gnt, imem_recv, imem_error;
  logic [31:0] imem_rdata;
  logic        dmem_req = 0, dmem_wen = 1, dmem_ack = 0;
  logic [3:0]  dmem_strb = 4'hC;
  logic [31:0] dmem_wdata = 32'h2222_0000, dmem_addr = DA;
  logic        dmem_gnt, dmem_recv, dmem_error;
  logic [31:0] dmem_rdata;
  logic        m_req, m_wen, m_ack;
  logic [3:0]  m_strb;
  logic [31:0] m_wdata, m_addr;
  logic        m_gnt = 0, m_recv = 0, m_error = 0;
  logic [31:0] m_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  scarv_mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_recv(imem_recv), .imem_error(imem_error), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_wdata(m_wdata),
    .m_addr(m_addr), .m_gnt(m_gnt), .m_recv(m_recv), .m_error(m_error),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  in;     // {ireq, dreq, gnt, recv, iack, dack}
    logic        emreq;
    logic [31:0] eaddr;
    logic [4:0]  eo;     // {ignt, dgnt, irecv, drecv, mack}
  } vec_t;

  vec_t tbl[12];

  // Reference model state: outstanding IDs in request order plus arbitration memory.
  int q[$];
  bit lastg, pend_valid, pend_sel, perr;
  logic        e_mreq, e_sel, e_wen, e_ignt, e_dgnt, e_irecv, e_drecv;
  logic        e_ierr, e_derr, e_mack;
  logic [3:0]  e_strb;
  logic [31:0] e_wdata, e_addr, e_irdata, e_drdata;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] in);
    {imem_req, dmem_req, m_gnt, m_recv, imem_ack, dmem_ack} = in;
    #1;
  endtask

  task automatic modelReset();
    q.delete();
    lastg = 0;
    pend_valid = 0;
    pend_sel = 0;
    perr = 0;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    {imem_req, dmem_req, m_gnt, m_recv, imem_ack, dmem_ack, m_error} = '0;
    modelReset();
    tick();
    tick();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic modelEval();
    bit empty, head;
    empty  = (q.size() == 0);
    head   = empty ? 1'b0 : q[0][0];
    e_mreq = (imem_req || dmem_req) && (q.size() < DEPTH);
    if (pend_valid && (pend_sel ? dmem_req : imem_req)) e_sel = pend_sel;
    else if (imem_req && dmem_req)                      e_sel = !lastg;
    else                                                e_sel = dmem_req;
    e_wen   = e_mreq ? (e_sel ? dmem_wen : imem_wen) : 1'b0;
    e_strb  = e_mreq ? (e_sel ? dmem_strb : imem_strb) : 4'h0;
    e_wdata = e_mreq ? (e_sel ? dmem_wdata : imem_wdata) : 32'h0;
    e_addr  = e_mreq ? (e_sel ? dmem_addr : imem_addr) : 32'h0;
    e_ignt  = e_mreq && m_gnt && !e_sel;
    e_dgnt  = e_mreq && m_gnt && e_sel;
    e_irecv  = !empty && !head && m_recv;
    e_drecv  = !empty && head && m_recv;
    e_ierr   = !empty && !head && m_error;
    e_derr   = !empty && head && m_error;
    e_irdata = (!empty && !head) ? m_rdata : 32'h0;
    e_drdata = (!empty && head) ? m_rdata : 32'h0;
    e_mack   = empty ? m_recv : (head ? dmem_ack : imem_ack);
  endtask

  task automatic modelClock();
    bit empty;
    empty = (q.size() == 0);
    if (m_recv && e_mack && !empty) void'(q.pop_front());
    if (e_mreq && m_gnt) begin
      q.push_back(int'(e_sel));
      lastg = e_sel;
    end
    pend_valid = e_mreq && !m_gnt;
    pend_sel   = e_sel;
    if (m_recv && empty) perr = 1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".m_req"}, 32'(m_req), 32'(e_mreq));
    checkOutput({tag, ".m_wen"}, 32'(m_wen), 32'(e_wen));
    checkOutput({tag, ".m_strb"}, 32'(m_strb), 32'(e_strb));
    checkOutput({tag, ".m_wdata"}, m_wdata, e_wdata);
    checkOutput({tag, ".m_addr"}, m_addr, e_addr);
    checkOutput({tag, ".gnt"}, 32'({imem_gnt, dmem_gnt}), 32'({e_ignt, e_dgnt}));
    checkOutput({tag, ".recv"}, 32'({imem_recv, dmem_recv}), 32'({e_irecv, e_drecv}));
    checkOutput({tag, ".error"}, 32'({imem_error, dmem_error}), 32'({e_ierr, e_derr}));
    checkOutput({tag, ".imem_rdata"}, imem_rdata, e_irdata);
    checkOutput({tag, ".dmem_rdata"}, dmem_rdata, e_drdata);
    checkOutput({tag, ".m_ack"}, 32'(m_ack), 32'(e_mack));
    checkOutput({tag, ".proto_err"}, 32'(dut.proto_err_q), 32'(perr));
  endtask

  initial begin
    tbl[0]  = '{6'b111000, 1'b1, DA,    5'b01000};
    tbl[1]  = '{6'b111000, 1'b1, IA,    5'b10000};
    tbl[2]  = '{6'b101000, 1'b0, 32'h0, 5'b00000};
    tbl[3]  = '{6'b101110, 1'b0, 32'h0, 5'b00010};
    tbl[4]  = '{6'b101101, 1'b0, 32'h0, 5'b00011};
    tbl[5]  = '{6'b011110, 1'b1, DA,    5'b01101};
    tbl[6]  = '{6'b000101, 1'b0, 32'h0, 5'b00011};
    tbl[7]  = '{6'b000100, 1'b0, 32'h0, 5'b00001};
    tbl[8]  = '{6'b010000, 1'b1, DA,    5'b00000};
    tbl[9]  = '{6'b110000, 1'b1, DA,    5'b00000};
    tbl[10] = '{6'b111000, 1'b1, DA,    5'b01000};
    tbl[11] = '{6'b111000, 1'b1, IA,    5'b10000};

    // Outputs must stay quiet under reset even with every input active.
    #1;
    applyStimulus(6'b111111);
    checkOutput("reset.m_req", 32'(m_req), 32'h0);
    checkOutput("reset.m_ack", 32'(m_ack), 32'h0);
    checkOutput("reset.gnt_recv", 32'({imem_gnt, dmem_gnt, imem_recv, dmem_recv}), 32'h0);
    checkOutput("reset.m_addr", m_addr, 32'h0);

    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].in);
      checkOutput($sformatf("tbl%0d.m_req", i), 32'(m_req), 32'(tbl[i].emreq));
      checkOutput($sformatf("tbl%0d.m_addr", i), m_addr, tbl[i].eaddr);
      checkOutput($sformatf("tbl%0d.flags", i),
                  32'({imem_gnt, dmem_gnt, imem_recv, dmem_recv, m_ack}), 32'(tbl[i].eo));
      tick();
      if (i == 7) checkOutput("tbl7.proto_err", 32'(dut.proto_err_q), 32'h1);
    end

    // Read data and error are steered only to the head port.
    doReset();
    applyStimulus(6'b101000);
    tick();
    m_rdata = 32'hDEADBEEF;
    m_error = 1'b1;
    applyStimulus(6'b000110);
    checkOutput("route.imem_rdata", imem_rdata, 32'hDEADBEEF);
    checkOutput("route.imem_error", 32'(imem_error), 32'h1);
    checkOutput("route.dmem_rdata", dmem_rdata, 32'h0);
    checkOutput("route.dmem_error", 32'(dmem_error), 32'h0);
    checkOutput("route.recv", 32'({imem_recv, dmem_recv, m_ack}), 32'b101);
    tick();
    m_error = 1'b0;
    m_rdata = 32'h0;

    // Asynchronous reset with two responses outstanding.
    doReset();
    applyStimulus(6'b111000);
    tick();
    applyStimulus(6'b111000);
    tick();
    applyStimulus(6'b101111);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("areset.count", 32'(dut.count_q), 32'h0);
    checkOutput("areset.m_req", 32'(m_req), 32'h0);
    checkOutput("areset.flags", 32'({imem_gnt, dmem_gnt, imem_recv, dmem_recv, m_ack}), 32'h0);
    rst_ni = 1'b1;
    applyStimulus(6'b000111);
    checkOutput("areset.orphan", 32'({imem_recv, dmem_recv, m_ack}), 32'b001);
    tick();
    checkOutput("areset.proto_err", 32'(dut.proto_err_q), 32'h1);

    // Randomized traffic against the reference model.
    doReset();
    for (int c = 0; c < 400; c++) begin
      imem_addr  = $urandom;
      dmem_addr  = $urandom;
      imem_wdata = $urandom;
      dmem_wdata = $urandom;
      imem_wen   = 1'($urandom_range(0, 1));
      dmem_wen   = 1'($urandom_range(0, 1));
      imem_strb  = 4'($urandom_range(0, 15));
      dmem_strb  = 4'($urandom_range(0, 15));
      m_rdata    = $urandom;
      m_error    = 1'($urandom_range(0, 1));
      applyStimulus(6'($urandom_range(0, 63)));
      modelEval();
      checkAll($sformatf("rnd%0d", c));
      modelClock();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
